// File: rtl/spimemio_pkg.sv
// spimemio_pkg: shared types and constants for the spimemio read-port arbiter.
package spimemio_pkg;

   // Default byte-address width, matching the spimemio addr port.
   localparam int ADDR_W_DEF = 24;

   // Port indices used for round-robin bookkeeping.
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // The encoding doubles as the one-hot grant vector (IDLE = no owner).
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } arb_state_t;

endpackage

// File: rtl/spimemio_arb_cache.sv
// spimemio_arb_cache: one-entry last-word cache for a single arbiter port.
// Only instantiated when SPIMEM_ARB_CACHE_EN is defined.
module spimemio_arb_cache
   import spimemio_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              fill,
   input  logic [ADDR_W-3:0] fill_tag,
   input  logic [31:0]       fill_data,
   input  logic [ADDR_W-3:0] lookup_tag,
   output logic              hit,
   output logic [31:0]       data
);

   logic              vld_r;
   logic [ADDR_W-3:0] tag_r;
   logic [31:0]       data_r;

   // Entry storage: flush takes priority over a coinciding fill.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_r  <= 1'b0;
         tag_r  <= {(ADDR_W-2){1'b0}};
         data_r <= 32'h0000_0000;
      end else if (flush) begin
         vld_r  <= 1'b0;
      end else if (fill) begin
         vld_r  <= 1'b1;
         tag_r  <= fill_tag;
         data_r <= fill_data;
      end
   end

   assign hit  = vld_r & (tag_r == lookup_tag);
   assign data = data_r;

endmodule

// File: rtl/spimemio_arbiter.sv
// spimemio_arbiter: round-robin sharing of one spimemio read port between
// instruction fetch (port 0) and the data bus (port 1). The grant is held
// until the owner's read completes so mem_addr never moves under a live read.
// Optional per-port last-word cache: define SPIMEM_ARB_CACHE_EN.
module spimemio_arbiter
   import spimemio_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int TIE_PORT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic [31:0]       m0_rdata,
   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic [31:0]       m1_rdata,
   input  logic              flush,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        grant
);

   arb_state_t  state_r;
   arb_state_t  state_nxt_s;
   logic        last_port_r;
   logic        hit0_s;
   logic        hit1_s;
   logic [31:0] cdata0_s;
   logic [31:0] cdata1_s;
   logic        req0_s;
   logic        req1_s;

`ifdef SPIMEM_ARB_CACHE_EN
   logic hit0_raw_s;
   logic hit1_raw_s;
   logic fill0_s;
   logic fill1_s;

   assign fill0_s = (state_r == OWN0) & m0_valid & mem_ready;
   assign fill1_s = (state_r == OWN1) & m1_valid & mem_ready;

   spimemio_arb_cache #(.ADDR_W(ADDR_W)) u_cache0 (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .fill       (fill0_s),
      .fill_tag   (m0_addr[ADDR_W-1:2]),
      .fill_data  (mem_rdata),
      .lookup_tag (m0_addr[ADDR_W-1:2]),
      .hit        (hit0_raw_s),
      .data       (cdata0_s)
   );

   spimemio_arb_cache #(.ADDR_W(ADDR_W)) u_cache1 (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .fill       (fill1_s),
      .fill_tag   (m1_addr[ADDR_W-1:2]),
      .fill_data  (mem_rdata),
      .lookup_tag (m1_addr[ADDR_W-1:2]),
      .hit        (hit1_raw_s),
      .data       (cdata1_s)
   );

   // Hits are only served while no port owns spimemio.
   assign hit0_s = (state_r == IDLE) & m0_valid & hit0_raw_s;
   assign hit1_s = (state_r == IDLE) & m1_valid & hit1_raw_s;
`else
   logic unused_flush_s;

   assign unused_flush_s = flush;
   assign hit0_s   = 1'b0;
   assign hit1_s   = 1'b0;
   assign cdata0_s = 32'h0000_0000;
   assign cdata1_s = 32'h0000_0000;
`endif

   // Arbitration state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Remember the last port served by spimemio; reset biases toward TIE_PORT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_port_r <= (TIE_PORT == 0) ? PORT1 : PORT0;
      end else if ((state_r == OWN0) && m0_valid && mem_ready) begin
         last_port_r <= PORT0;
      end else if ((state_r == OWN1) && m1_valid && mem_ready) begin
         last_port_r <= PORT1;
      end
   end

   // Next-state and pass-through muxing of the owning port onto spimemio.
   always_comb begin
      state_nxt_s = state_r;
      mem_valid   = 1'b0;
      mem_addr    = {ADDR_W{1'b0}};
      m0_ready    = 1'b0;
      m1_ready    = 1'b0;
      m0_rdata    = mem_rdata;
      m1_rdata    = mem_rdata;
      req0_s      = 1'b0;
      req1_s      = 1'b0;
      case (state_r)
         IDLE: begin
            m0_ready = hit0_s;
            m1_ready = hit1_s;
            if (hit0_s) begin
               m0_rdata = cdata0_s;
            end else begin
               m0_rdata = mem_rdata;
            end
            if (hit1_s) begin
               m1_rdata = cdata1_s;
            end else begin
               m1_rdata = mem_rdata;
            end
            req0_s = m0_valid & ~hit0_s;
            req1_s = m1_valid & ~hit1_s;
            if (req0_s && req1_s) begin
               state_nxt_s = (last_port_r == PORT0) ? OWN1 : OWN0;
            end else if (req0_s) begin
               state_nxt_s = OWN0;
            end else if (req1_s) begin
               state_nxt_s = OWN1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         OWN0: begin
            mem_valid = m0_valid;
            mem_addr  = m0_addr;
            m0_ready  = mem_ready & m0_valid;
            // A dropped valid is an abort; release without error.
            if (!m0_valid || mem_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = OWN0;
            end
         end
         OWN1: begin
            mem_valid = m1_valid;
            mem_addr  = m1_addr;
            m1_ready  = mem_ready & m1_valid;
            if (!m1_valid || mem_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = OWN1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   assign grant = 2'(state_r);

endmodule

// File: tb/tb_spimemio_arbiter.sv
// tb_spimemio_arbiter: self-checking bench for spimemio_arbiter with a
// behavioural spimemio responder and transaction-level scoreboarding.
module tb_spimemio_arbiter;

   localparam int AW = 24;

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_valid, m0_ready, m1_valid, m1_ready;
   logic [AW-1:0] m0_addr, m1_addr, mem_addr;
   logic [31:0]   m0_rdata, m1_rdata, mem_rdata;
   logic          flush, mem_valid, mem_ready;
   logic [1:0]    grant;

   int checks = 0;
   int errors = 0;
   int lat    = 2;
   int mem_cnt;

   spimemio_arbiter #(.ADDR_W(AW), .TIE_PORT(0)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_rdata(m1_rdata),
      .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .grant(grant)
   );

   always #5 clk = ~clk;

   // Flash contents as seen by the bench.
   function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
      if (a == 24'h000100) return 32'hDEADBEEF;
      return {a[15:0] ^ 16'hC3A5, a[23:8] ^ 16'h1234};
   endfunction

   // spimemio responder: ready after 'lat' stall cycles of a held request.
   assign mem_ready = mem_valid && (mem_cnt == lat);
   assign mem_rdata = mem_fn(mem_addr);
   always @(posedge clk or posedge reset) begin
      if (reset) mem_cnt <= 0;
      else if (!mem_valid || mem_ready) mem_cnt <= 0;
      else mem_cnt <= mem_cnt + 1;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Let any outstanding requests complete, dropping each valid on its ready.
   task automatic drain();
      logic r0, r1;
      for (int c = 0; c < 100; c++) begin
         if (!m0_valid && !m1_valid) break;
         @(negedge clk);
         r0 = m0_ready; r1 = m1_ready;
         step();
         if (r0) m0_valid = 1'b0;
         if (r1) m1_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; flush = 1'b0;
      m0_addr = '0; m1_addr = '0;
      #12;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
      checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", m0_ready, m1_ready); end
      step(); reset = 1'b0;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL idle_no_req grant got=%b exp=00", grant); end
      step();
   endtask

   task automatic test_single();
      int  cyc = 0, n_rdy = 0, rdy_cyc = -1;
      bit  m1_seen = 0, done = 0;
      lat = 11; m0_addr = 24'h000100; m0_valid = 1'b1;
      @(negedge clk);
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_arb_cycle mem_valid got=%b exp=0", mem_valid); end
      step(); @(negedge clk);
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 24'h000100 || grant !== 2'b01) begin
         errors++; $display("FAIL single_issue valid=%b addr=%h grant=%b exp 1/000100/01", mem_valid, mem_addr, grant); end
      while (!done && cyc < 40) begin
         if (m1_ready) m1_seen = 1;
         if (m0_ready) begin
            n_rdy++; rdy_cyc = cyc; done = 1;
            checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef", m0_rdata); end
         end
         step(); if (done) m0_valid = 1'b0;
         @(negedge clk); cyc++;
      end
      checks++; if (rdy_cyc != 11) begin errors++; $display("FAIL single_latency got=%0d exp=11", rdy_cyc); end
      checks++; if (m0_ready !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL single_release ready=%b grant=%b exp 0/00", m0_ready, grant); end
      checks++; if (m1_seen) begin errors++; $display("FAIL single_stray_m1_ready got=1 exp=0"); end
      step();
   endtask

   task automatic test_contention();
      logic [1:0] gq[$];
      int         order[$];
      logic       r0, r1;
      logic [7:0] g4;
      reset = 1'b1; step(); reset = 1'b0;
      lat = 2; m0_addr = 24'h000010; m1_addr = 24'h000020;
      m0_valid = 1'b1; m1_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (gq.size() == 0 || gq[$] !== grant) gq.push_back(grant);
         r0 = m0_ready; r1 = m1_ready;
         if (r0) begin order.push_back(0);
            checks++; if (m0_rdata !== mem_fn(24'h000010)) begin errors++; $display("FAIL cont_rdata0 got=%h exp=%h", m0_rdata, mem_fn(24'h000010)); end end
         if (r1) begin order.push_back(1);
            checks++; if (m1_rdata !== mem_fn(24'h000020)) begin errors++; $display("FAIL cont_rdata1 got=%h exp=%h", m1_rdata, mem_fn(24'h000020)); end end
         step();
         if (r0) m0_valid = 1'b0;
         if (r1) m1_valid = 1'b0;
         if (!m0_valid && !m1_valid) break;
      end
      g4 = (gq.size() >= 4) ? {gq[0], gq[1], gq[2], gq[3]} : 8'hFF;
      checks++; if (g4 !== 8'b00_01_00_10) begin errors++; $display("FAIL cont_grant_seq got=%b exp=00010010", g4); end
      checks++; if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin errors++; $display("FAIL cont_order got_n=%0d exp port0 then port1", order.size()); end
   endtask

   task automatic test_back_to_back();
      int         last = -1, n = 0;
      bit         prev_pend = 0;
      logic [AW-1:0] prev_addr = '0;
      logic       r0, r1;
      m0_addr = {6'h0, 16'($urandom), 2'b00}; m1_addr = {6'h0, 16'($urandom), 2'b00};
      m0_valid = 1'b1; m1_valid = 1'b1;
      for (int c = 0; c < 300 && n < 10; c++) begin
         @(negedge clk);
         if (prev_pend) begin
            checks++; if (mem_valid !== 1'b1 || mem_addr !== prev_addr) begin errors++; $display("FAIL b2b_addr_stable got=%h exp=%h", mem_addr, prev_addr); end
         end
         prev_pend = mem_valid && !mem_ready; prev_addr = mem_addr;
         r0 = m0_ready; r1 = m1_ready;
         if (r0 || r1) begin
            n++;
            checks++; if (r0 ? (m0_rdata !== mem_fn(m0_addr)) : (m1_rdata !== mem_fn(m1_addr))) begin errors++; $display("FAIL b2b_rdata port=%0d", r0 ? 0 : 1); end
            if (last >= 0) begin
               checks++; if ((r0 ? 0 : 1) == last) begin errors++; $display("FAIL b2b_alternate got=%0d exp=%0d", last, 1 - last); end
            end
            last = r0 ? 0 : 1;
         end
         step();
         if (r0) m0_addr = {6'h0, 16'($urandom), 2'b00};
         if (r1) m1_addr = {6'h0, 16'($urandom), 2'b00};
         if (!mem_valid) lat = $urandom_range(0, 4);
      end
      checks++; if (n != 10) begin errors++; $display("FAIL b2b_count got=%0d exp=10", n); end
      m0_valid = 1'b0; m1_valid = 1'b0; step(); step();
   endtask

   task automatic test_abort();
      bit stray = 0, done = 0;
      lat = 20; m1_addr = 24'h000080; m1_valid = 1'b1;
      @(negedge clk); step();
      m0_addr = 24'h000090; m0_valid = 1'b1;
      @(negedge clk);
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL abort_own1 got=%b exp=10", grant); end
      step(); @(negedge clk); step();
      m1_valid = 1'b0;
      @(negedge clk);
      checks++; if (m1_ready !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL abort_drop ready=%b valid=%b exp 0/0", m1_ready, mem_valid); end
      step(); @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abort_idle got=%b exp=00", grant); end
      step(); @(negedge clk);
      checks++; if (grant !== 2'b01 || mem_addr !== 24'h000090) begin errors++; $display("FAIL abort_regrant grant=%b addr=%h exp 01/000090", grant, mem_addr); end
      for (int c = 0; c < 40 && !done; c++) begin
         if (m1_ready) stray = 1;
         if (m0_ready) begin done = 1;
            checks++; if (m0_rdata !== mem_fn(24'h000090)) begin errors++; $display("FAIL abort_rdata got=%h exp=%h", m0_rdata, mem_fn(24'h000090)); end end
         step(); if (done) m0_valid = 1'b0;
         @(negedge clk);
      end
      checks++; if (!done || stray) begin errors++; $display("FAIL abort_finish done=%b stray_m1=%b exp 1/0", done, stray); end
      step();
   endtask

   task automatic test_async_reset();
      bit found = 0;
      lat = 3; m0_addr = 24'h000044; m0_valid = 1'b1;
      drain();
      lat = 20; m1_addr = 24'h000048; m1_valid = 1'b1;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (grant === 2'b10) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL areset_reach_own1 got=%b exp=10", grant); end
      #2 reset = 1'b1;
      #1;
      checks++; if (mem_valid !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL areset_immediate valid=%b grant=%b exp 0/00", mem_valid, grant); end
      step();
      m0_addr = 24'h000050; m1_addr = 24'h000054; m0_valid = 1'b1; m1_valid = 1'b1;
      step(); reset = 1'b0;
      @(negedge clk); step(); @(negedge clk);
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL areset_tie_port got=%b exp=01", grant); end
      lat = 2; drain(); step();
   endtask

`ifdef SPIMEM_ARB_CACHE_EN
   task automatic test_cache();
      lat = 3; m0_addr = 24'h000040; m0_valid = 1'b1;
      drain(); step();
      m0_valid = 1'b1;
      @(negedge clk);
      checks++; if (m0_ready !== 1'b1 || mem_valid !== 1'b0 || m0_rdata !== mem_fn(24'h000040)) begin
         errors++; $display("FAIL cache_hit ready=%b mem_valid=%b rdata=%h exp 1/0/%h", m0_ready, mem_valid, m0_rdata, mem_fn(24'h000040)); end
      step(); m0_valid = 1'b0; flush = 1'b1;
      step(); flush = 1'b0; m0_valid = 1'b1;
      @(negedge clk);
      checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL cache_flush_miss got=%b exp=0", m0_ready); end
      step(); @(negedge clk);
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 24'h000040) begin errors++; $display("FAIL cache_refetch valid=%b addr=%h", mem_valid, mem_addr); end
      drain(); step();
   endtask
`endif

   task automatic test_random();
      localparam int N = 25;
      logic          v[2], rdy[2];
      logic [AW-1:0] a[2];
      int            gap[2], done[2], wo[2];
      bit            prev_pend = 0;
      logic [AW-1:0] prev_addr = '0;
      logic [31:0]   rd;
      for (int p = 0; p < 2; p++) begin v[p] = 0; a[p] = '0; gap[p] = 0; done[p] = 0; wo[p] = 0; end
      for (int c = 0; c < 3000 && (done[0] < N || done[1] < N); c++) begin
         @(negedge clk);
         rdy[0] = m0_ready; rdy[1] = m1_ready;
         checks++; if (grant === 2'b11 || $isunknown(grant)) begin errors++; $display("FAIL rand_grant_onehot got=%b", grant); end
         if (prev_pend) begin
            checks++; if (mem_valid !== 1'b1 || mem_addr !== prev_addr) begin errors++; $display("FAIL rand_addr_stable got=%h exp=%h", mem_addr, prev_addr); end
         end
         prev_pend = mem_valid && !mem_ready; prev_addr = mem_addr;
         for (int p = 0; p < 2; p++) begin
            if (rdy[p]) begin
               rd = (p == 0) ? m0_rdata : m1_rdata;
               checks++; if (!v[p] || rd !== mem_fn(a[p])) begin errors++; $display("FAIL rand_rdata port=%0d got=%h exp=%h valid=%b", p, rd, mem_fn(a[p]), v[p]); end
               checks++; if (wo[p] > 1) begin errors++; $display("FAIL rand_starvation port=%0d waited=%0d exp<=1", p, wo[p]); end
               if (grant[p] && v[1-p]) wo[1-p]++;
            end
         end
         step();
         for (int p = 0; p < 2; p++) begin
            if (rdy[p]) begin
               v[p] = 0; done[p]++; gap[p] = $urandom_range(0, 3);
            end else if (!v[p] && done[p] < N) begin
               if (gap[p] == 0) begin v[p] = 1; a[p] = {19'h0, 3'($urandom_range(0, 7)), 2'b00}; wo[p] = 0; end
               else gap[p]--;
            end
         end
         m0_valid = v[0]; m0_addr = a[0]; m1_valid = v[1]; m1_addr = a[1];
         if (!mem_valid) lat = $urandom_range(0, 5);
      end
      checks++; if (done[0] != N || done[1] != N) begin errors++; $display("FAIL rand_complete got=%0d/%0d exp=%0d", done[0], done[1], N); end
      m0_valid = 1'b0; m1_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_abort();
      test_async_reset();
`ifdef SPIMEM_ARB_CACHE_EN
      test_cache();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
